// File: rtl/mig_app_arbiter.sv
// Arbitrates one write client and two read clients onto a Xilinx MIG user (app) interface.
// Read returns are routed back to the issuing client through an in-order tag FIFO.
module mig_app_arbiter #(
    parameter int ADDR_W    = 29,
    parameter int DATA_W    = 256,
    parameter int MASK_W    = 32,
    parameter int TAG_DEPTH = 8
) (
    input  logic              ui_clk,
    input  logic              sys_rst,
    input  logic              init_calib_complete,
    input  logic              wr_valid,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic              wr_ready,
    input  logic              rd0_valid,
    input  logic [ADDR_W-1:0] rd0_addr,
    output logic              rd0_ready,
    output logic [DATA_W-1:0] rd0_data,
    output logic              rd0_data_valid,
    input  logic              rd1_valid,
    input  logic [ADDR_W-1:0] rd1_addr,
    output logic              rd1_ready,
    output logic [DATA_W-1:0] rd1_data,
    output logic              rd1_data_valid,
    output logic [ADDR_W-1:0] app_addr,
    output logic [2:0]        app_cmd,
    output logic              app_en,
    output logic [DATA_W-1:0] app_wdf_data,
    output logic              app_wdf_wren,
    output logic              app_wdf_end,
    output logic [MASK_W-1:0] app_wdf_mask,
    input  logic              app_rdy,
    input  logic              app_wdf_rdy,
    input  logic [DATA_W-1:0] app_rd_data,
    input  logic              app_rd_data_valid,
    output logic              busy,
    output logic              err_orphan
);
    localparam int PTR_W = (TAG_DEPTH > 1) ? $clog2(TAG_DEPTH) : 1;
    localparam int CNT_W = $clog2(TAG_DEPTH + 1);
    localparam logic [2:0] CMD_WR = 3'b000;
    localparam logic [2:0] CMD_RD = 3'b001;

    typedef enum logic [1:0] {ST_INIT, ST_IDLE, ST_WR, ST_RD} state_t;

    state_t              state_q, state_d;
    logic [1:0]          rr_q, rr_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [2:0]          cmd_q, cmd_d;
    logic                en_q, en_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic                wren_q, wren_d;
    logic                cur_id_q, cur_id_d;
    logic                busy_q, busy_d;
    logic                err_q, err_d;
    logic [TAG_DEPTH-1:0] tag_q, tag_d;
    logic [PTR_W-1:0]    wptr_q, wptr_d, rptr_q, rptr_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [DATA_W-1:0]   rd0_data_q, rd0_data_d, rd1_data_q, rd1_data_d;
    logic                rd0_vld_q, rd0_vld_d, rd1_vld_q, rd1_vld_d;
    logic [2:0]          elig_s, gnt_s;
    logic                push_s, pop_s, pop_id_s;

    // Round-robin pick: ptr names the client (0=W, 1=R0, 2=R1) that has first claim.
    function automatic logic [2:0] rr_pick(input logic [2:0] elig, input logic [1:0] ptr);
        logic [2:0] rot;
        logic [2:0] g;
        case (ptr)
            2'd1:    rot = {elig[0], elig[2], elig[1]};
            2'd2:    rot = {elig[1], elig[0], elig[2]};
            default: rot = elig;
        endcase
        g = rot[0] ? 3'b001 : (rot[1] ? 3'b010 : (rot[2] ? 3'b100 : 3'b000));
        case (ptr)
            2'd1:    return {g[1], g[0], g[2]};
            2'd2:    return {g[0], g[2], g[1]};
            default: return g;
        endcase
    endfunction

    // Arbitration, command FSM, tag FIFO and read-return next-state logic.
    always_comb begin
        state_d  = state_q;
        rr_d     = rr_q;
        addr_d   = addr_q;
        cmd_d    = cmd_q;
        en_d     = en_q;
        wdata_d  = wdata_q;
        wren_d   = wren_q;
        cur_id_d = cur_id_q;
        push_s   = 1'b0;

        elig_s[0] = wr_valid;
        elig_s[1] = rd0_valid && (cnt_q < CNT_W'(TAG_DEPTH));
        elig_s[2] = rd1_valid && (cnt_q < CNT_W'(TAG_DEPTH));
        if (state_q == ST_IDLE && init_calib_complete) begin
            gnt_s = rr_pick(elig_s, rr_q);
        end else begin
            gnt_s = 3'b000;
        end

        case (state_q)
            ST_INIT: begin
                state_d = init_calib_complete ? ST_IDLE : ST_INIT;
            end
            ST_IDLE: begin
                if (!init_calib_complete) begin
                    state_d = ST_INIT;
                end else if (gnt_s[0]) begin
                    state_d = ST_WR;
                    cmd_d   = CMD_WR;
                    addr_d  = wr_addr;
                    wdata_d = wr_data;
                    en_d    = 1'b1;
                    wren_d  = 1'b1;
                    rr_d    = 2'd1;
                end else if (gnt_s[1] || gnt_s[2]) begin
                    state_d  = ST_RD;
                    cmd_d    = CMD_RD;
                    addr_d   = gnt_s[1] ? rd0_addr : rd1_addr;
                    cur_id_d = gnt_s[2];
                    en_d     = 1'b1;
                    rr_d     = gnt_s[1] ? 2'd2 : 2'd0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WR: begin
                // Command and data acceptance are independent; leave once both have happened.
                en_d   = en_q && !app_rdy;
                wren_d = wren_q && !app_wdf_rdy;
                if (!en_d && !wren_d) begin
                    state_d = init_calib_complete ? ST_IDLE : ST_INIT;
                end else begin
                    state_d = ST_WR;
                end
            end
            ST_RD: begin
                if (en_q && app_rdy) begin
                    en_d    = 1'b0;
                    push_s  = 1'b1;
                    state_d = init_calib_complete ? ST_IDLE : ST_INIT;
                end else begin
                    state_d = ST_RD;
                end
            end
            default: begin
                state_d = ST_INIT;
            end
        endcase
        busy_d = (state_d != ST_IDLE);

        pop_s    = app_rd_data_valid && (cnt_q != CNT_W'(0));
        pop_id_s = tag_q[rptr_q];
        err_d    = err_q || (app_rd_data_valid && (cnt_q == CNT_W'(0)));
        tag_d    = tag_q;
        wptr_d   = wptr_q;
        rptr_d   = rptr_q;
        if (push_s) begin
            tag_d[wptr_q] = cur_id_q;
            wptr_d        = wptr_q + PTR_W'(1);
        end else begin
            wptr_d = wptr_q;
        end
        if (pop_s) begin
            rptr_d = rptr_q + PTR_W'(1);
        end else begin
            rptr_d = rptr_q;
        end
        case ({push_s, pop_s})
            2'b10:   cnt_d = cnt_q + CNT_W'(1);
            2'b01:   cnt_d = cnt_q - CNT_W'(1);
            default: cnt_d = cnt_q;
        endcase

        rd0_vld_d  = pop_s && !pop_id_s;
        rd1_vld_d  = pop_s && pop_id_s;
        rd0_data_d = rd0_vld_d ? app_rd_data : rd0_data_q;
        rd1_data_d = rd1_vld_d ? app_rd_data : rd1_data_q;
    end

    // State and datapath registers; reset abandons any command and drops all tags.
    always_ff @(posedge ui_clk or negedge sys_rst) begin
        if (!sys_rst) begin
            state_q    <= ST_INIT;
            rr_q       <= 2'd0;
            addr_q     <= '0;
            cmd_q      <= CMD_WR;
            en_q       <= 1'b0;
            wdata_q    <= '0;
            wren_q     <= 1'b0;
            cur_id_q   <= 1'b0;
            busy_q     <= 1'b0;
            err_q      <= 1'b0;
            tag_q      <= '0;
            wptr_q     <= '0;
            rptr_q     <= '0;
            cnt_q      <= '0;
            rd0_data_q <= '0;
            rd1_data_q <= '0;
            rd0_vld_q  <= 1'b0;
            rd1_vld_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            rr_q       <= rr_d;
            addr_q     <= addr_d;
            cmd_q      <= cmd_d;
            en_q       <= en_d;
            wdata_q    <= wdata_d;
            wren_q     <= wren_d;
            cur_id_q   <= cur_id_d;
            busy_q     <= busy_d;
            err_q      <= err_d;
            tag_q      <= tag_d;
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
            cnt_q      <= cnt_d;
            rd0_data_q <= rd0_data_d;
            rd1_data_q <= rd1_data_d;
            rd0_vld_q  <= rd0_vld_d;
            rd1_vld_q  <= rd1_vld_d;
        end
    end

    assign wr_ready       = gnt_s[0];
    assign rd0_ready      = gnt_s[1];
    assign rd1_ready      = gnt_s[2];
    assign app_addr       = addr_q;
    assign app_cmd        = cmd_q;
    assign app_en         = en_q;
    assign app_wdf_data   = wdata_q;
    assign app_wdf_wren   = wren_q;
    assign app_wdf_end    = wren_q;
    assign app_wdf_mask   = {MASK_W{1'b0}};
    assign rd0_data       = rd0_data_q;
    assign rd0_data_valid = rd0_vld_q;
    assign rd1_data       = rd1_data_q;
    assign rd1_data_valid = rd1_vld_q;
    assign busy           = busy_q;
    assign err_orphan     = err_q;
endmodule

// File: tb/tb_mig_app_arbiter.sv
// Directed bench for mig_app_arbiter: accepted MIG commands and routed read data are
// compared against scoreboard queues filled as stimulus is driven.
module tb_mig_app_arbiter;
    localparam int ADDR_W = 29, DATA_W = 256, MASK_W = 32, TAG_DEPTH = 8;

    logic              ui_clk = 1'b0;
    logic              sys_rst, init_calib_complete;
    logic              wr_valid, wr_ready, rd0_valid, rd0_ready, rd1_valid, rd1_ready;
    logic [ADDR_W-1:0] wr_addr, rd0_addr, rd1_addr, app_addr;
    logic [DATA_W-1:0] wr_data, rd0_data, rd1_data, app_wdf_data, app_rd_data;
    logic              rd0_data_valid, rd1_data_valid;
    logic [2:0]        app_cmd;
    logic              app_en, app_wdf_wren, app_wdf_end, app_rdy, app_wdf_rdy;
    logic [MASK_W-1:0] app_wdf_mask;
    logic              app_rd_data_valid, busy, err_orphan;

    mig_app_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MASK_W(MASK_W), .TAG_DEPTH(TAG_DEPTH)) dut (
        .ui_clk(ui_clk), .sys_rst(sys_rst), .init_calib_complete(init_calib_complete),
        .wr_valid(wr_valid), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ready(wr_ready),
        .rd0_valid(rd0_valid), .rd0_addr(rd0_addr), .rd0_ready(rd0_ready),
        .rd0_data(rd0_data), .rd0_data_valid(rd0_data_valid),
        .rd1_valid(rd1_valid), .rd1_addr(rd1_addr), .rd1_ready(rd1_ready),
        .rd1_data(rd1_data), .rd1_data_valid(rd1_data_valid),
        .app_addr(app_addr), .app_cmd(app_cmd), .app_en(app_en),
        .app_wdf_data(app_wdf_data), .app_wdf_wren(app_wdf_wren), .app_wdf_end(app_wdf_end),
        .app_wdf_mask(app_wdf_mask), .app_rdy(app_rdy), .app_wdf_rdy(app_wdf_rdy),
        .app_rd_data(app_rd_data), .app_rd_data_valid(app_rd_data_valid),
        .busy(busy), .err_orphan(err_orphan)
    );

    always #5 ui_clk = ~ui_clk;

    typedef struct packed {
        logic [2:0]        cmd;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } cmd_t;
    typedef struct packed {
        logic              client;
        logic [DATA_W-1:0] data;
    } rd_t;

    cmd_t cmd_exp[$];
    rd_t  rd_exp[$];
    cmd_t mon_c;
    rd_t  mon_r;
    int   n_chk = 0;
    int   n_pass = 0;

    task automatic check_eq(input string tag, input logic [DATA_W-1:0] got, input logic [DATA_W-1:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge ui_clk);
        #1;
    endtask

    task automatic push_cmd(input logic [2:0] c, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        cmd_t e;
        e.cmd = c; e.addr = a; e.data = d;
        cmd_exp.push_back(e);
    endtask

    task automatic push_rd(input logic client, input logic [DATA_W-1:0] d);
        rd_t e;
        e.client = client; e.data = d;
        rd_exp.push_back(e);
    endtask

    task automatic ret(input logic [DATA_W-1:0] d);
        app_rd_data = d;
        app_rd_data_valid = 1'b1;
        tick();
        app_rd_data_valid = 1'b0;
    endtask

    task automatic do_reset(input logic calib);
        check_eq("cmd_queue_left", cmd_exp.size(), 0);
        check_eq("rd_queue_left", rd_exp.size(), 0);
        sys_rst = 1'b0; init_calib_complete = calib;
        wr_valid = 1'b0; rd0_valid = 1'b0; rd1_valid = 1'b0;
        wr_addr = '0; rd0_addr = '0; rd1_addr = '0; wr_data = '0;
        app_rdy = 1'b1; app_wdf_rdy = 1'b1; app_rd_data_valid = 1'b0; app_rd_data = '0;
        @(negedge ui_clk);
        check_eq("rst_app_en", app_en, 0);
        check_eq("rst_wren", app_wdf_wren, 0);
        check_eq("rst_cmd", app_cmd, 0);
        check_eq("rst_addr", app_addr, 0);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_err", err_orphan, 0);
        check_eq("rst_rd0_data", rd0_data, 0);
        tick();
        sys_rst = 1'b1;
        tick();
    endtask

    // k: 0=write, 1=read0, 2=read1; holds valid until the ready pulse, then drops it.
    task automatic request(input int k, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        logic got;
        got = 1'b0;
        case (k)
            0:       begin wr_valid = 1'b1; wr_addr = a; wr_data = d; end
            1:       begin rd0_valid = 1'b1; rd0_addr = a; end
            default: begin rd1_valid = 1'b1; rd1_addr = a; end
        endcase
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge ui_clk);
            got = (k == 0) ? wr_ready : ((k == 1) ? rd0_ready : rd1_ready);
        end
        check_eq($sformatf("grant_k%0d", k), got, 1);
        tick();
        wr_valid = 1'b0; rd0_valid = 1'b0; rd1_valid = 1'b0;
    endtask

    // Scoreboard monitor, sampled mid-cycle when the coming edge's inputs are stable.
    always @(negedge ui_clk) begin
        if (sys_rst === 1'b1 && app_en && app_rdy) begin
            check_eq("cmd_expected", cmd_exp.size() > 0, 1);
            if (cmd_exp.size() > 0) begin
                mon_c = cmd_exp.pop_front();
                check_eq("cmd_op", app_cmd, mon_c.cmd);
                check_eq("cmd_addr", app_addr, mon_c.addr);
                if (mon_c.cmd == 3'b000) check_eq("cmd_wdata", app_wdf_data, mon_c.data);
            end
        end
        if (rd0_data_valid || rd1_data_valid) begin
            check_eq("rd_expected", rd_exp.size() > 0, 1);
            check_eq("rd_single", rd0_data_valid && rd1_data_valid, 0);
            if (rd_exp.size() > 0) begin
                mon_r = rd_exp.pop_front();
                check_eq("rd_client", rd1_data_valid, mon_r.client);
                check_eq("rd_data", rd1_data_valid ? rd1_data : rd0_data, mon_r.data);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int seen, en_n, wren_n, multi;
        logic end_ok, saw_rd, saw_wr, got;
        int order[$];

        // Calibration hold
        do_reset(1'b0);
        push_cmd(3'b000, 29'h40, 256'h3);
        wr_valid = 1'b1; wr_addr = 29'h40; wr_data = 256'h3;
        seen = 0;
        repeat (3) begin
            @(negedge ui_clk);
            if (wr_ready || app_en) seen++;
        end
        check_eq("calib_hold", seen, 0);
        check_eq("calib_busy", busy, 1);
        tick();
        init_calib_complete = 1'b1;
        @(negedge ui_clk);
        check_eq("calib_init_ready", wr_ready, 0);
        @(negedge ui_clk);
        check_eq("calib_idle_ready", wr_ready, 1);
        check_eq("calib_idle_en", app_en, 0);
        tick();
        wr_valid = 1'b0;
        @(negedge ui_clk);
        check_eq("calib_en", app_en, 1);
        check_eq("calib_wren", app_wdf_wren, 1);
        check_eq("calib_ready_pulse", wr_ready, 0);
        repeat (2) tick();

        // Write under data backpressure
        push_cmd(3'b000, 29'h10, 256'hA5);
        app_wdf_rdy = 1'b0;
        wr_valid = 1'b1; wr_addr = 29'h10; wr_data = 256'hA5;
        @(negedge ui_clk);
        check_eq("bp_ready", wr_ready, 1);
        tick();
        wr_valid = 1'b0;
        en_n = 0; wren_n = 0; end_ok = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            @(negedge ui_clk);
            en_n += int'(app_en);
            wren_n += int'(app_wdf_wren);
            if (app_wdf_end !== app_wdf_wren) end_ok = 1'b0;
            if (k == 1) check_eq("bp_busy_in", busy, 1);
            if (k == 5) check_eq("bp_busy_after", busy, 0);
            tick();
            if (k >= 3) app_wdf_rdy = 1'b1;
        end
        check_eq("bp_en_cycles", en_n, 1);
        check_eq("bp_wren_cycles", wren_n, 4);
        check_eq("bp_wdf_end", end_ok, 1);
        check_eq("bp_mask", app_wdf_mask, 0);

        // Round-robin with all clients continuously valid
        do_reset(1'b1);
        for (int i = 0; i < 2; i++) begin
            push_cmd(3'b000, 29'h100, 256'h55);
            push_cmd(3'b001, 29'h200, 256'h0);
            push_cmd(3'b001, 29'h300, 256'h0);
        end
        wr_valid = 1'b1; wr_addr = 29'h100; wr_data = 256'h55;
        rd0_valid = 1'b1; rd0_addr = 29'h200;
        rd1_valid = 1'b1; rd1_addr = 29'h300;
        multi = 0;
        for (int i = 0; i < 60 && order.size() < 6; i++) begin
            @(negedge ui_clk);
            if (int'(wr_ready) + int'(rd0_ready) + int'(rd1_ready) > 1) multi++;
            if (wr_ready) order.push_back(0);
            else if (rd0_ready) order.push_back(1);
            else if (rd1_ready) order.push_back(2);
            tick();
            if (order.size() >= 6) begin
                wr_valid = 1'b0; rd0_valid = 1'b0; rd1_valid = 1'b0;
            end
        end
        check_eq("rr_one_hot", multi, 0);
        for (int i = 0; i < 6; i++)
            check_eq($sformatf("rr_order_%0d", i), (i < order.size()) ? order[i] : 99, i % 3);
        repeat (3) tick();
        for (int j = 0; j < 4; j++) begin
            push_rd(j[0], 256'h1000 + 256'(j));
            ret(256'h1000 + 256'(j));
        end
        repeat (2) tick();

        // Tag routing
        do_reset(1'b1);
        push_cmd(3'b001, 29'd8, 256'h0);
        request(1, 29'd8, 256'h0);
        push_cmd(3'b001, 29'd16, 256'h0);
        request(2, 29'd16, 256'h0);
        repeat (2) tick();
        push_rd(1'b0, 256'h1);
        push_rd(1'b1, 256'h2);
        app_rd_data = 256'h1; app_rd_data_valid = 1'b1;
        tick();
        app_rd_data = 256'h2;
        @(negedge ui_clk);
        check_eq("tag_rd0_valid", rd0_data_valid, 1);
        check_eq("tag_rd0_data", rd0_data, 256'h1);
        check_eq("tag_rd1_quiet", rd1_data_valid, 0);
        tick();
        app_rd_data_valid = 1'b0;
        @(negedge ui_clk);
        check_eq("tag_rd0_pulse", rd0_data_valid, 0);
        check_eq("tag_rd1_valid", rd1_data_valid, 1);
        check_eq("tag_rd1_data", rd1_data, 256'h2);
        @(negedge ui_clk);
        check_eq("tag_rd1_pulse", rd1_data_valid, 0);
        check_eq("tag_rd0_hold", rd0_data, 256'h1);
        check_eq("tag_no_err", err_orphan, 0);

        // Outstanding limit
        do_reset(1'b1);
        for (int i = 0; i < TAG_DEPTH; i++) begin
            push_cmd(3'b001, 29'h20 + 29'(i), 256'h0);
            request((i % 2) + 1, 29'h20 + 29'(i), 256'h0);
        end
        repeat (2) tick();
        push_cmd(3'b000, 29'h500, 256'hBEEF);
        push_cmd(3'b001, 29'h600, 256'h0);
        rd0_valid = 1'b1; rd0_addr = 29'h600;
        wr_valid = 1'b1; wr_addr = 29'h500; wr_data = 256'hBEEF;
        saw_rd = 1'b0; saw_wr = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge ui_clk);
            saw_rd |= rd0_ready;
            saw_wr |= wr_ready;
            tick();
            if (saw_wr) wr_valid = 1'b0;
        end
        check_eq("lim_read_blocked", saw_rd, 0);
        check_eq("lim_write_granted", saw_wr, 1);
        push_rd(1'b0, 256'h77);
        ret(256'h77);
        got = 1'b0;
        for (int i = 0; i < 10 && !got; i++) begin
            @(negedge ui_clk);
            got = rd0_ready;
        end
        check_eq("lim_read_after_return", got, 1);
        tick();
        rd0_valid = 1'b0;
        repeat (3) tick();

        // Orphan data, reset mid-write, data returning after reset
        do_reset(1'b1);
        ret(256'h99);
        @(negedge ui_clk);
        check_eq("orphan_set", err_orphan, 1);
        repeat (3) tick();
        check_eq("orphan_sticky", err_orphan, 1);
        push_cmd(3'b001, 29'h44, 256'h0);
        request(1, 29'h44, 256'h0);
        repeat (2) tick();
        app_rdy = 1'b0; app_wdf_rdy = 1'b0;
        request(0, 29'h30, 256'h12);
        @(negedge ui_clk);
        check_eq("midwr_en", app_en, 1);
        #1 sys_rst = 1'b0;
        #1;
        check_eq("midrst_en", app_en, 0);
        check_eq("midrst_wren", app_wdf_wren, 0);
        check_eq("midrst_err", err_orphan, 0);
        tick();
        app_rdy = 1'b1; app_wdf_rdy = 1'b1;
        sys_rst = 1'b1;
        tick();
        ret(256'h5A);
        @(negedge ui_clk);
        check_eq("postrst_orphan", err_orphan, 1);
        check_eq("postrst_rd0", rd0_data_valid, 0);

        repeat (3) tick();
        check_eq("cmd_queue_empty", cmd_exp.size(), 0);
        check_eq("rd_queue_empty", rd_exp.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/mig_app_arbiter.md
MIG_APP_ARBITER -- requirements
Module: mig_app_arbiter

Interface
REQ-001 The block SHALL have these parameters (name, default, meaning), one per line:
- ADDR_W, 29, MIG app address width
- DATA_W, 256, MIG app data width
- MASK_W, 32, write mask width (DATA_W/8)
- TAG_DEPTH, 8, maximum outstanding reads (power of 2)

REQ-002 The block SHALL have one clock and an asynchronous, active-low reset; ports (name, direction, width, meaning), one per line:
- ui_clk, in, 1, MIG user-interface clock; all logic is on its rising edge
- sys_rst, in, 1, asynchronous active-low reset
- init_calib_complete, in, 1, MIG calibration done
- wr_valid / wr_addr / wr_data, in, 1/ADDR_W/DATA_W, write client request
- wr_ready, out, 1, one-cycle pulse when the write request is captured
- rdK_valid / rdK_addr (K=0,1), in, 1/ADDR_W, read client K request
- rdK_ready, out, 1, one-cycle pulse when read K is captured
- rdK_data / rdK_data_valid, out, DATA_W/1, read data returned to client K
- app_addr / app_cmd / app_en, out, ADDR_W/3/1, MIG command port
- app_wdf_data / app_wdf_wren / app_wdf_end / app_wdf_mask, out, DATA_W/1/1/MASK_W, MIG write-data port
- app_rdy / app_wdf_rdy, in, 1/1, MIG ready signals
- app_rd_data / app_rd_data_valid, in, DATA_W/1, MIG read return
- busy, out, 1, high whenever the FSM is in any state other than IDLE
- err_orphan, out, 1, sticky flag: read data arrived with no outstanding tag

Function
REQ-003 FSM states SHALL be INIT, IDLE, WR and RD.
- INIT -> IDLE when init_calib_complete=1 is sampled.
- No client is granted in INIT.
REQ-004 In IDLE, the block SHALL grant one eligible client per cycle using round-robin.
- Order: W, R0, R1.
- Priority pointer moves to the client after the winner.
- A read client is eligible only if outstanding < TAG_DEPTH.
REQ-005 On a grant in cycle t, the block SHALL:
- pulse the winner's ready in cycle t;
- latch addr (and data for writes);
- move to WR or RD, with app_en=1 from cycle t+1.
REQ-006 In WR, the block SHALL drive app_cmd=3'b000 and assert app_en and app_wdf_wren together at entry.
- app_en stays high until sampled with app_rdy=1.
- app_wdf_wren stays high until sampled with app_wdf_wren&app_wdf_rdy=1.
- The two acceptances are tracked independently.
- Return to IDLE in the cycle after both are accepted.
REQ-007 In RD, the block SHALL drive app_cmd=3'b001 and hold app_en=1 until sampled with app_rdy=1, then return to IDLE.
REQ-008 app_addr, app_cmd and app_wdf_data SHALL remain stable while app_en or app_wdf_wren is high.
REQ-009 The block SHALL drive app_wdf_end equal to app_wdf_wren and app_wdf_mask equal to all zeros at all times.
REQ-010 On read command acceptance (app_en&app_rdy in RD), the block SHALL push the client ID into a TAG_DEPTH-deep tag FIFO.
REQ-011 On app_rd_data_valid=1, the block SHALL pop the tag FIFO and present app_rd_data on rdK_data with rdK_data_valid=1 for exactly one cycle.
- Latency: one cycle (registered).
- rdK_data holds its value otherwise.
REQ-012 Push and pop in the same cycle SHALL both take effect; outstanding stays unchanged.
REQ-013 The outstanding count SHALL range from 0 to TAG_DEPTH and SHALL never wrap.
- FIFO pointers wrap modulo TAG_DEPTH.
REQ-014 If app_rd_data_valid=1 while the tag FIFO is empty, the block SHALL:
- set err_orphan=1 and hold it until reset;
- discard the data;
- leave both rdK_data_valid low.
REQ-015 If init_calib_complete falls outside INIT, the in-flight command SHALL complete before the FSM returns to INIT; no new grants are made.
REQ-016 A client that deasserts valid before its ready pulse SHALL NOT be granted; valid dropping after capture SHALL NOT affect the captured command.

Reset
REQ-017 While sys_rst=0, the block SHALL reset asynchronously to:
- state INIT, priority pointer at W;
- all outputs 0 (app_cmd 3'b000, all data and address outputs zero);
- outstanding 0, FIFO pointers 0, err_orphan 0.
REQ-018 A reset asserted mid-transaction SHALL abandon the command and clear all tags; read data returning after reset SHALL be handled per REQ-014.

Verification
REQ-019 The bench SHALL cover these directed scenarios:
- Calibration hold: wr_valid=1 with init_calib_complete=0 -> no wr_ready, app_en=0; raise calib -> wr_ready one cycle after IDLE entry, app_en=1 on the next cycle.
- Write under backpressure: write addr 0x10, data 0xA5; app_rdy=1, app_wdf_rdy=0 for 3 cycles -> app_en drops after 1 cycle; wdf_wren/wdf_end held 4 cycles; busy=0 one cycle after data accepted.
- Round-robin: W, R0 and R1 all continuously valid -> grants W, R0, R1, W, R0, R1.
- Tag routing: R0 reads addr 8, then R1 reads addr 16; return data 0x1 then 0x2 -> rd0_data=0x1 first, then rd1_data=0x2, each valid one cycle.
- Outstanding limit: 8 reads issued with no return -> 9th read not granted while a pending write is still granted; one return -> 9th read granted.
- Errors and reset: app_rd_data_valid with empty FIFO -> err_orphan=1 and held; sys_rst=0 mid-WR -> app_en=0, app_wdf_wren=0 immediately, err_orphan=0.
